data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers CPU data-port requests after a
// fixed number of wait states, with lane-masked writes and fault reporting.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   req    - level request, held by the CPU until ready is seen
//   we     - byte-lane write enables (0 = read)
//   addr   - byte address
//   wdata  - store data, lane i = wdata[8i+7:8i]
//   ready  - one-cycle completion pulse
//   rdata  - load data, nonzero only while ready is high
//   err    - misaligned / out-of-range fault, valid while ready is high
//   busy   - high whenever an access is in flight
module data_mem_responder #(
  parameter int unsigned AW_WORDS    = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << AW_WORDS;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic [31:0]          addr_q;
  logic [3:0]           we_q;
  logic [31:0]          wdata_q;

  logic [31:0]          acc_addr;
  logic [3:0]           acc_we;
  logic [31:0]          acc_wdata;
  logic [AW_WORDS-1:0]  acc_idx;
  logic                 acc_fault;
  logic                 enter_resp;

  logic [31:0]          mem [DEPTH];

  // State register and captured request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == ST_IDLE && req) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
    end
  end

  // Next-state logic and access qualification
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt != '0) cnt_next = cnt - CW'(1);
        else           state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // With zero wait states the access completes on the accept edge itself,
  // so the live inputs are used instead of the not-yet-captured copies.
  always_comb begin
    acc_addr   = (state == ST_IDLE) ? addr  : addr_q;
    acc_we     = (state == ST_IDLE) ? we    : we_q;
    acc_wdata  = (state == ST_IDLE) ? wdata : wdata_q;
    acc_idx    = acc_addr[AW_WORDS+1:2];
    acc_fault  = (acc_addr[1:0] != 2'b00) ||
                 ((acc_addr >> (AW_WORDS + 2)) != 32'd0);
    enter_resp = (state_next == ST_RESP);
  end

  // Registered response; rdata/err are zero outside the ready cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      busy  <= 1'b0;
    end else begin
      ready <= enter_resp;
      err   <= enter_resp && acc_fault;
      rdata <= (enter_resp && !acc_fault && acc_we == 4'b0000) ? mem[acc_idx] : 32'd0;
      busy  <= (state_next != ST_IDLE);
    end
  end

  // Storage: no reset so contents survive rst; rst gates writes so an
  // access cut short by reset never lands.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_we[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (2, 0 and 15 wait states)
// driven from a reference memory model; expected responses are queued at
// the accept edge and matched against each ready pulse.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req_v;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rdy;
  logic [2:0]  er;
  logic [2:0]  bsy;
  logic [31:0] rd [3];

  int checks;
  int errors;
  int cyc;
  int busy_cnt;
  logic [2:0] prev_rdy;
  logic [31:0] mdl [3][256];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  data_mem_responder #(.AW_WORDS(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
    .ready(rdy[0]), .rdata(rd[0]), .err(er[0]), .busy(bsy[0]));
  data_mem_responder #(.AW_WORDS(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
    .ready(rdy[1]), .rdata(rd[1]), .err(er[1]), .busy(bsy[1]));
  data_mem_responder #(.AW_WORDS(8), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
    .ready(rdy[2]), .rdata(rd[2]), .err(er[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int wc(input int s);
    return (s == 0) ? 2 : (s == 1) ? 0 : 15;
  endfunction

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
  endfunction

  task automatic qpush(input int s, input exp_t e);
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int s, output exp_t e);
    case (s)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Reference model: called just after the accept edge
  task automatic expect_acc(input int s, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d);
    exp_t e;
    logic [7:0] idx;
    idx   = a[9:2];
    e.cyc = cyc + wc(s);
    if (a[1:0] != 2'b00 || a[31:10] != 22'd0) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
    end else if (w != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (w[i]) mdl[s][idx][8*i +: 8] = d[8*i +: 8];
      e.rdata = 32'd0;
      e.err   = 1'b0;
    end else begin
      e.rdata = mdl[s][idx];
      e.err   = 1'b0;
    end
    qpush(s, e);
  endtask

  task automatic mon(input int s);
    exp_t e;
    if (rdy[s]) begin
      chk("no_consecutive_ready", 32'(prev_rdy[s]), 32'd0);
      if (qsize(s) == 0) begin
        chk("spurious_ready", 32'(rdy[s]), 32'd0);
      end else begin
        qpop(s, e);
        chk("rdata", rd[s], e.rdata);
        chk("err", 32'(er[s]), 32'(e.err));
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (rst) begin
      chk("idle_rdata", rd[s], 32'd0);
      chk("idle_err", 32'(er[s]), 32'd0);
    end
    prev_rdy[s] = rdy[s];
  endtask

  always @(negedge clk) begin
    if (bsy[0]) busy_cnt++;
    for (int s = 0; s < 3; s++) mon(s);
  end

  task automatic drain(input int s);
    for (int t = 0; t < 40 && qsize(s) != 0; t++) @(posedge clk);
    chk("response_timeout", 32'(qsize(s)), 32'd0);
    while (qsize(s) != 0) begin
      exp_t e;
      qpop(s, e);
    end
  endtask

  task automatic access(input int s, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    busy_cnt = 0;
    we = w; addr = a; wdata = d;
    req_v[s] = 1'b1;
    @(posedge clk);
    #1;
    expect_acc(s, w, a, d);
    req_v[s] = 1'b0;
    drain(s);
    @(negedge clk);
    if (s == 0) begin
      chk("busy_cycles", 32'(busy_cnt), 32'd3);
      chk("busy_low_after", 32'(bsy[0]), 32'd0);
    end
  endtask

  // Write that gets reset while in WAIT; model left untouched
  task automatic aborted_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 4'hF; addr = a; wdata = d;
    req_v[0] = 1'b1;
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(bsy[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy[0]), 32'd0);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_err", 32'(er[0]), 32'd0);
    chk("abort_rdata", rd[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [3:0]  hw_we   [6];
  logic [31:0] hw_addr [6];
  logic [31:0] hw_data [6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; busy_cnt = 0; prev_rdy = '0;
    rst = 1'b0; req_v = '0; we = '0; addr = '0; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("reset_ready", 32'(rdy[s]), 32'd0);
      chk("reset_busy", 32'(bsy[s]), 32'd0);
      chk("reset_err", 32'(er[s]), 32'd0);
      chk("reset_rdata", rd[s], 32'd0);
    end
    rst = 1'b1;

    access(0, 4'hF, 32'h10, 32'hDEADBEEF);
    access(0, 4'h0, 32'h10, 32'h0);
    access(0, 4'b0010, 32'h10, 32'h0000AA00);
    access(0, 4'h0, 32'h10, 32'h0);
    access(0, 4'h0, 32'h12, 32'h0);
    access(0, 4'h0, 32'h400, 32'h0);
    access(0, 4'hF, 32'h0, 32'h11111111);
    access(0, 4'hF, 32'h400, 32'hCAFEF00D);
    access(0, 4'h0, 32'h0, 32'h0);

    access(0, 4'hF, 32'h20, 32'h0);
    aborted_write(32'h20, 32'h12345678);
    access(0, 4'h0, 32'h20, 32'h0);
    access(0, 4'h0, 32'h10, 32'h0);

    // Zero wait states with req held high across back-to-back accesses
    hw_we[0] = 4'hF; hw_addr[0] = 32'h0; hw_data[0] = 32'hA5A50001;
    hw_we[1] = 4'hF; hw_addr[1] = 32'h4; hw_data[1] = 32'h5A5A0002;
    hw_we[2] = 4'h3; hw_addr[2] = 32'h0; hw_data[2] = 32'hFFFF1234;
    hw_we[3] = 4'h0; hw_addr[3] = 32'h0; hw_data[3] = 32'h0;
    hw_we[4] = 4'h0; hw_addr[4] = 32'h4; hw_data[4] = 32'h0;
    hw_we[5] = 4'h0; hw_addr[5] = 32'h7; hw_data[5] = 32'h0;
    @(negedge clk);
    we = hw_we[0]; addr = hw_addr[0]; wdata = hw_data[0];
    req_v[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      expect_acc(1, hw_we[i], hw_addr[i], hw_data[i]);
      @(negedge clk);
      if (i < 5) begin
        we = hw_we[i+1]; addr = hw_addr[i+1]; wdata = hw_data[i+1];
      end else begin
        req_v[1] = 1'b0;
      end
      @(posedge clk);
    end
    drain(1);

    access(2, 4'hF, 32'h40, 32'h0BADC0DE);
    access(2, 4'h0, 32'h40, 32'h0);

    // Randomised lane-masked traffic over a few words
    for (int i = 0; i < 4; i++) access(0, 4'hF, 32'(i * 4), $urandom);
    for (int i = 0; i < 8; i++)
      access(0, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 3) * 4), $urandom);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
